joint_stepdir_in: RTL and testbench

Step/direction input decoder: the receive-side counterpart of the joint step generator. It samples external STP/DIR pins, which may come from another controller or from a loopback of our own generator. It accumulates a signed 32-bit step position and reports the measured step rate as a signed command in the same units the step generator consumes. It sits between the FPGA input pins and the position/feedback registers sent to the host.

---
 rtl/joint_stepdir_in_if.sv | 23 ++
 rtl/joint_stepdir_in.sv | 141 ++++++++++++++
 tb/tb_joint_stepdir_in.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/joint_stepdir_in_if.sv
// Step/direction decoder signal bundle: pin inputs, position preset and the
// decoded position/rate outputs.
interface joint_stepdir_in_if;
  logic               jointEnable;
  logic               STP;
  logic               DIR;
  logic               load;
  logic signed [31:0] loadValue;
  logic signed [31:0] position;
  logic signed [31:0] jointFreqCmd;
  logic               stepPulse;
  logic               rateValid;

  modport master (
    output jointEnable, STP, DIR, load, loadValue,
    input  position, jointFreqCmd, stepPulse, rateValid
  );

  modport slave (
    input  jointEnable, STP, DIR, load, loadValue,
    output position, jointFreqCmd, stepPulse, rateValid
  );
endinterface

// File: rtl/joint_stepdir_in.sv
// Step/direction input decoder: synchronizes and filters STP/DIR, accumulates
// a signed position and converts the measured step period to a generator command.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no reference edge yet (or timed out / disabled); rate = 0
// ST_ARMED | pc counts clocks since the last step; next step gives a rate
module joint_stepdir_in #(
  parameter int unsigned FILTER  = 2,
  parameter int unsigned TIMEOUT = 10_000_000
) (
  input logic               clk,
  input logic               rst,
  joint_stepdir_in_if.slave bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  localparam int unsigned   FW       = $clog2(FILTER + 2);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER);
  localparam logic [31:0]   PC_MAX   = 32'(TIMEOUT);

  logic               stp_s1_q, stp_s2_q;
  logic               dir_s1_q, dir_s2_q;
  logic               stpf_q, stpf_d;
  logic [FW-1:0]      flt_cnt_q, flt_cnt_d;
  logic               step_evt;
  logic signed [31:0] pos_q, pos_d;
  logic               pulse_q, pulse_d;
  logic signed [31:0] cmd_q, cmd_d;
  logic               valid_q, valid_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        half, mag;
  state_e             state_q, state_d;

  // The level flips on the (FILTER+1)th consecutive differing sample, and the
  // step is taken on that same edge, so pin-to-output latency is FILTER+3 clocks.
  always_comb begin
    stpf_d    = stpf_q;
    flt_cnt_d = '0;
    step_evt  = 1'b0;
    if (stp_s2_q != stpf_q) begin
      if (flt_cnt_q == FLT_LAST) begin
        stpf_d   = stp_s2_q;
        step_evt = stp_s2_q & bus.jointEnable;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    pos_d   = pos_q;
    pulse_d = step_evt;
    if (bus.load) begin
      pos_d = bus.loadValue;
    end else if (step_evt) begin
      pos_d = dir_s2_q ? pos_q + 32'sd1 : pos_q - 32'sd1;
    end
  end

  // Inverse of the generator mapping period = 2(N+1); never emit 0 (= stop).
  assign half = pc_q >> 1;
  assign mag  = (half > 32'd1) ? half - 32'd1 : 32'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cmd_d   = cmd_q;
    valid_d = valid_q;
    if (!bus.jointEnable) begin
      state_d = ST_IDLE;
      cmd_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_d   = '0;
          valid_d = 1'b0;
          if (step_evt) begin
            pc_d    = 32'd1;
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (step_evt) begin
            cmd_d   = dir_s2_q ? $signed(mag) : -$signed(mag);
            valid_d = 1'b1;
            pc_d    = 32'd1;
          end else if (pc_q >= PC_MAX) begin
            cmd_d   = '0;
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            pc_d = pc_q + 32'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stp_s1_q  <= 1'b0;
      stp_s2_q  <= 1'b0;
      dir_s1_q  <= 1'b0;
      dir_s2_q  <= 1'b0;
      stpf_q    <= 1'b0;
      flt_cnt_q <= '0;
      pos_q     <= '0;
      pulse_q   <= 1'b0;
      cmd_q     <= '0;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      state_q   <= ST_IDLE;
    end else begin
      stp_s1_q  <= bus.STP;
      stp_s2_q  <= stp_s1_q;
      dir_s1_q  <= bus.DIR;
      dir_s2_q  <= dir_s1_q;
      stpf_q    <= stpf_d;
      flt_cnt_q <= flt_cnt_d;
      pos_q     <= pos_d;
      pulse_q   <= pulse_d;
      cmd_q     <= cmd_d;
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      state_q   <= state_d;
    end
  end

  assign bus.position     = pos_q;
  assign bus.jointFreqCmd = cmd_q;
  assign bus.stepPulse    = pulse_q;
  assign bus.rateValid    = valid_q;

endmodule

// File: tb/tb_joint_stepdir_in.sv
// Bench for joint_stepdir_in: directed scenarios plus random pin traffic,
// compared against a pin-history / step-timestamp reference model.
module tb_joint_stepdir_in;
  localparam int FILTER  = 2;
  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  joint_stepdir_in_if bus ();

  joint_stepdir_in #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: raw pin samples, accepted level, step timestamps.
  logic [15:0]        m_stp_h, m_dir_h;
  logic               m_lv, m_pulse, m_armed, m_valid;
  logic signed [31:0] m_pos, m_cmd;
  int                 m_cyc, m_last, m_pulses, dut_pulses;

  task automatic model_reset();
    m_stp_h = '0; m_dir_h = '0; m_lv = 1'b0; m_pulse = 1'b0;
    m_armed = 1'b0; m_valid = 1'b0; m_pos = '0; m_cmd = '0;
    m_cyc = 0; m_last = 0;
  endtask

  task automatic model_update();
    bit diff, stp;
    int p;
    logic [31:0] mg;
    m_cyc++;
    m_stp_h = {m_stp_h[14:0], bus.STP};
    m_dir_h = {m_dir_h[14:0], bus.DIR};
    // accept a new level once FILTER+1 consecutive samples (two clocks old) disagree
    diff = 1'b1;
    for (int i = 2; i <= 2 + FILTER; i++) if (m_stp_h[i] == m_lv) diff = 1'b0;
    stp = 1'b0;
    if (diff) begin
      m_lv = ~m_lv;
      stp  = m_lv & bus.jointEnable;
    end
    if (bus.load) m_pos = bus.loadValue;
    else if (stp) m_pos = m_dir_h[2] ? m_pos + 1 : m_pos - 1;
    if (!bus.jointEnable) begin
      m_armed = 1'b0; m_cmd = '0; m_valid = 1'b0;
    end else if (stp) begin
      if (m_armed) begin
        p  = m_cyc - m_last;
        mg = ((p / 2) > 1) ? 32'(p / 2 - 1) : 32'd1;
        m_cmd   = m_dir_h[2] ? $signed(mg) : -$signed(mg);
        m_valid = 1'b1;
      end
      m_armed = 1'b1;
      m_last  = m_cyc;
    end else if (m_armed && (m_cyc - m_last) >= TIMEOUT) begin
      m_armed = 1'b0; m_cmd = '0; m_valid = 1'b0;
    end
    m_pulse = stp;
    if (stp) m_pulses++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_update();
    @(negedge clk);
    if (bus.stepPulse === 1'b1) dut_pulses++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.jointEnable = 1'b0; bus.STP = 1'b0; bus.DIR = 1'b0;
    bus.load = 1'b0; bus.loadValue = '0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (bus.position !== 32'sd0) begin n_fail++; $display("FAIL reset_position got=%0d want=0", bus.position); end
    n_tests++;
    if (bus.jointFreqCmd !== 32'sd0) begin n_fail++; $display("FAIL reset_cmd got=%0d want=0", bus.jointFreqCmd); end
    n_tests++;
    if ({bus.stepPulse, bus.rateValid} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b want=00", {bus.stepPulse, bus.rateValid}); end
  endtask

  task automatic test_count_rate();
    int p0;
    apply_reset();
    bus.jointEnable = 1'b1; bus.DIR = 1'b1;
    repeat (4) tick();
    p0 = dut_pulses;
    for (int e = 0; e < 5; e++) begin
      for (int c = 0; c < 20; c++) begin
        bus.STP = (c < 10);
        tick();
        n_tests++;
        if ({bus.position, bus.jointFreqCmd, bus.rateValid, bus.stepPulse} !== {m_pos, m_cmd, m_valid, m_pulse}) begin
          n_fail++;
          $display("FAIL count_rate cyc=%0d pos=%0d/%0d cmd=%0d/%0d valid=%b/%b pulse=%b/%b", m_cyc,
                   bus.position, m_pos, bus.jointFreqCmd, m_cmd, bus.rateValid, m_valid, bus.stepPulse, m_pulse);
        end
      end
      if (e == 1) begin
        n_tests++;
        if (bus.jointFreqCmd !== 32'sd9 || bus.rateValid !== 1'b1) begin
          n_fail++; $display("FAIL count_rate_cmd got=%0d/%b want=9/1", bus.jointFreqCmd, bus.rateValid);
        end
      end
    end
    n_tests++;
    if (bus.position !== 32'sd5) begin n_fail++; $display("FAIL count_rate_pos got=%0d want=5", bus.position); end
    n_tests++;
    if (dut_pulses - p0 != 5) begin n_fail++; $display("FAIL count_rate_pulses got=%0d want=5", dut_pulses - p0); end
  endtask

  task automatic test_reverse_wrap();
    apply_reset();
    bus.jointEnable = 1'b1; bus.DIR = 1'b0;
    repeat (3) tick();
    bus.load = 1'b1; bus.loadValue = 32'sh80000001;
    tick();
    bus.load = 1'b0;
    n_tests++;
    if (bus.position !== 32'sh80000001) begin n_fail++; $display("FAIL wrap_load got=%h want=80000001", bus.position); end
    for (int e = 0; e < 3; e++) begin
      for (int c = 0; c < 20; c++) begin
        bus.STP = (c < 10);
        tick();
        n_tests++;
        if ({bus.position, bus.jointFreqCmd, bus.rateValid, bus.stepPulse} !== {m_pos, m_cmd, m_valid, m_pulse}) begin
          n_fail++;
          $display("FAIL wrap cyc=%0d pos=%h/%h cmd=%0d/%0d valid=%b/%b pulse=%b/%b", m_cyc,
                   bus.position, m_pos, bus.jointFreqCmd, m_cmd, bus.rateValid, m_valid, bus.stepPulse, m_pulse);
        end
      end
      if (e == 1) begin
        n_tests++;
        if (!(bus.jointFreqCmd < 0) || bus.rateValid !== 1'b1) begin
          n_fail++; $display("FAIL wrap_negative_cmd got=%0d/%b want=<0/1", bus.jointFreqCmd, bus.rateValid);
        end
      end
    end
    n_tests++;
    if (bus.position !== 32'sh7FFFFFFE) begin n_fail++; $display("FAIL wrap_pos got=%h want=7ffffffe", bus.position); end
  endtask

  task automatic test_glitch();
    int p0;
    apply_reset();
    bus.jointEnable = 1'b1; bus.DIR = 1'b1;
    repeat (4) tick();
    p0 = dut_pulses;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < ((k == 3) ? 11 : 8); c++) begin
        bus.STP = (c < ((k == 3) ? 3 : 2));
        tick();
        n_tests++;
        if ({bus.position, bus.stepPulse} !== {m_pos, m_pulse}) begin
          n_fail++; $display("FAIL glitch cyc=%0d pos=%0d/%0d pulse=%b/%b", m_cyc, bus.position, m_pos, bus.stepPulse, m_pulse);
        end
      end
      if (k == 2) begin
        n_tests++;
        if (dut_pulses != p0) begin n_fail++; $display("FAIL glitch_short got=%0d want=0 pulses", dut_pulses - p0); end
      end
    end
    n_tests++;
    if (dut_pulses - p0 != 1 || bus.position !== 32'sd1) begin
      n_fail++; $display("FAIL glitch_accept pulses=%0d pos=%0d want=1/1", dut_pulses - p0, bus.position);
    end
  endtask

  task automatic test_timeout();
    int p0;
    apply_reset();
    bus.jointEnable = 1'b1; bus.DIR = 1'b1;
    repeat (4) tick();
    for (int c = 0; c < 170; c++) begin
      bus.STP = (c < 5) || (c >= 40 && c < 45);
      tick();
      n_tests++;
      if ({bus.position, bus.jointFreqCmd, bus.rateValid, bus.stepPulse} !== {m_pos, m_cmd, m_valid, m_pulse}) begin
        n_fail++;
        $display("FAIL timeout cyc=%0d cmd=%0d/%0d valid=%b/%b", m_cyc, bus.jointFreqCmd, m_cmd, bus.rateValid, m_valid);
      end
      if (c == 50) begin
        n_tests++;
        if (bus.jointFreqCmd !== 32'sd19 || bus.rateValid !== 1'b1) begin
          n_fail++; $display("FAIL timeout_rate got=%0d/%b want=19/1", bus.jointFreqCmd, bus.rateValid);
        end
      end
    end
    n_tests++;
    if (bus.jointFreqCmd !== 32'sd0 || bus.rateValid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_zero got=%0d/%b want=0/0", bus.jointFreqCmd, bus.rateValid);
    end
    p0 = dut_pulses;
    bus.STP = 1'b1; repeat (5) tick();
    bus.STP = 1'b0; repeat (5) tick();
    n_tests++;
    if (dut_pulses - p0 != 1 || bus.rateValid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_rearm pulses=%0d valid=%b want=1/0", dut_pulses - p0, bus.rateValid);
    end
  endtask

  task automatic test_load_disable();
    logic signed [31:0] lv, held;
    int p0;
    apply_reset();
    bus.jointEnable = 1'b1; bus.DIR = 1'b1;
    repeat (4) tick();
    lv = $signed($urandom);
    bus.STP = 1'b1;
    repeat (4) tick();
    bus.load = 1'b1; bus.loadValue = lv;
    tick();
    bus.load = 1'b0;
    n_tests++;
    if (bus.stepPulse !== 1'b1 || bus.position !== lv) begin
      n_fail++; $display("FAIL load_collision pulse=%b pos=%h want=1/%h", bus.stepPulse, bus.position, lv);
    end
    bus.STP = 1'b0; repeat (5) tick();
    held = lv;
    bus.jointEnable = 1'b0;
    p0 = dut_pulses;
    for (int c = 0; c < 45; c++) begin
      bus.STP = (c % 10) < 5 || c == 44;
      tick();
      n_tests++;
      if ({bus.position, bus.jointFreqCmd, bus.rateValid} !== {held, 32'sd0, 1'b0}) begin
        n_fail++; $display("FAIL disable cyc=%0d pos=%h/%h cmd=%0d valid=%b", m_cyc, bus.position, held, bus.jointFreqCmd, bus.rateValid);
      end
    end
    bus.jointEnable = 1'b1;
    repeat (8) tick();
    n_tests++;
    if (dut_pulses != p0) begin n_fail++; $display("FAIL reenable_high_pulses got=%0d want=0", dut_pulses - p0); end
    bus.jointEnable = 1'b0; bus.load = 1'b1; bus.loadValue = ~lv;
    tick();
    bus.load = 1'b0;
    n_tests++;
    if (bus.position !== ~lv) begin n_fail++; $display("FAIL disabled_load got=%h want=%h", bus.position, ~lv); end
  endtask

  task automatic test_async_reset();
    int p0;
    apply_reset();
    bus.jointEnable = 1'b1; bus.DIR = 1'b1;
    for (int c = 0; c < 50; c++) begin bus.STP = (c % 20) < 10; tick(); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.position, bus.jointFreqCmd, bus.rateValid} !== {32'sd0, 32'sd0, 1'b0}) begin
      n_fail++; $display("FAIL async_reset pos=%0d cmd=%0d valid=%b want=0/0/0", bus.position, bus.jointFreqCmd, bus.rateValid);
    end
    bus.STP = 1'b0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    p0 = dut_pulses;
    bus.STP = 1'b1; repeat (6) tick();
    bus.STP = 1'b0; repeat (6) tick();
    n_tests++;
    if (dut_pulses - p0 != 1 || bus.rateValid !== 1'b0 || bus.position !== 32'sd1) begin
      n_fail++; $display("FAIL reset_first_step pulses=%0d valid=%b pos=%0d want=1/0/1", dut_pulses - p0, bus.rateValid, bus.position);
    end
  endtask

  task automatic test_random();
    int run;
    apply_reset();
    bus.jointEnable = 1'b1;
    run = 0;
    for (int c = 0; c < 1500; c++) begin
      if (run == 0) begin
        bus.STP = ~bus.STP;
        run = ($urandom_range(0, 29) == 0) ? 120 : int'($urandom_range(1, 7));
      end
      run--;
      if ($urandom_range(0, 9) == 0) bus.DIR = ~bus.DIR;
      if ($urandom_range(0, 79) == 0) bus.jointEnable = ~bus.jointEnable;
      bus.load = ($urandom_range(0, 39) == 0);
      bus.loadValue = ($urandom_range(0, 3) == 0) ? 32'sh7FFFFFFF : $signed($urandom);
      tick();
      n_tests++;
      if ({bus.position, bus.jointFreqCmd, bus.rateValid, bus.stepPulse} !== {m_pos, m_cmd, m_valid, m_pulse}) begin
        n_fail++;
        $display("FAIL random cyc=%0d pos=%h/%h cmd=%0d/%0d valid=%b/%b pulse=%b/%b", m_cyc,
                 bus.position, m_pos, bus.jointFreqCmd, m_cmd, bus.rateValid, m_valid, bus.stepPulse, m_pulse);
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_loopback();
    apply_reset();
    bus.jointEnable = 1'b1; bus.DIR = 1'b1;
    repeat (4) tick();
    // generator at command 7: 8 clocks high, 8 low
    for (int p = 0; p < 10; p++) begin
      for (int c = 0; c < 16; c++) begin
        bus.STP = (c < 8);
        tick();
      end
      if (p >= 2) begin
        n_tests++;
        if (bus.jointFreqCmd !== 32'sd7 || bus.rateValid !== 1'b1 || bus.position !== 32'(p + 1)) begin
          n_fail++;
          $display("FAIL loopback period=%0d cmd=%0d pos=%0d want=7/%0d", p, bus.jointFreqCmd, bus.position, p + 1);
        end
      end
    end
  endtask

  initial begin
    m_pulses = 0; dut_pulses = 0;
    test_reset();
    test_count_rate();
    test_reverse_wrap();
    test_glitch();
    test_timeout();
    test_load_disable();
    test_async_reset();
    test_random();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
